branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: IDX_W, default 4, BHT index width (2^IDX_W entries).
REQ-002 Parameter: Q_DEPTH, default 4, in-flight prediction queue depth (power of two).
REQ-003 Port: clk  input  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: if_valid  input  1  fetch-stage instruction valid.
REQ-006 Port: if_pc  input  32  fetch-stage PC.
REQ-007 Port: if_inst  input  32  fetch-stage instruction word.
REQ-008 Port: prediction  output  1  taken prediction for the current fetch (combinational).
REQ-009 Port: bp_stall  output  1  fetch must hold; queue full on a branch fetch (combinational).
REQ-010 Port: res_valid  input  1  execute stage resolves the oldest in-flight branch this cycle.
REQ-011 Port: res_taken  input  1  actual branch outcome.
REQ-012 Port: mispredict  output  1  res_taken differs from stored prediction of queue head (combinational, gated by res_valid and queue non-empty).
REQ-013 Port: res_err  output  1  registered one-cycle pulse: res_valid seen with queue empty.
REQ-014 Port: mispredict_cnt  output  16  saturating count of mispredictions.

Function
REQ-015 Branch fetch = if_valid and if_inst[6:0] == 7'b1100011.
REQ-016 Lookup index = if_pc[IDX_W+1:2]; prediction = MSB of 2-bit counter at that index for a branch fetch, else 0.
REQ-017 Push {index, prediction} on a branch fetch when queue not full and no mispredict this cycle.
REQ-018 Branch fetch with queue full: bp_stall = 1, prediction = 0, no push; non-branch fetches never stall.
REQ-019 On res_valid with queue non-empty: pop head; update counter at head index, taken -> saturating increment (max 2'b11), not taken -> saturating decrement (min 2'b00).
REQ-020 On mispredict: after pop, discard all remaining entries (count = 0, rd_ptr = wr_ptr) and suppress any same-cycle push.
REQ-021 Simultaneous push and pop without mispredict: both occur, occupancy unchanged; allowed when full (pop frees slot in same cycle, bp_stall deasserted).
REQ-022 Lookup and update of the same index in one cycle: lookup returns pre-update value (no bypass).
REQ-023 res_valid with queue empty: no counter update, no pointer change, mispredict = 0, res_err pulses next cycle.
REQ-024 mispredict_cnt increments by 1 per mispredict cycle, holds at 16'hFFFF.
REQ-025 Queue pointers are log2(Q_DEPTH)+1 bits; wrap naturally; full = MSBs differ and low bits equal.

Reset
REQ-026 rst_n low asynchronously: all BHT counters = 2'b01 (weakly not-taken), queue empty, pointers 0, res_err = 0, mispredict_cnt = 0.
REQ-027 Reset mid-operation discards all in-flight entries; no update is performed for them.
REQ-028 First rising clk edge after rst_n deassertion is a normal operating cycle.

Structure
REQ-029 Shared package bp_pkg holds OPCODE_BRANCH (7'b1100011), default IDX_W/Q_DEPTH, counter encodings SNT/WNT/WT/ST, and the queue-entry struct {idx, pred}.
REQ-030 One sub-module bp_queue: parameterised FIFO with push, pop, clear, full, empty, head data.

Verification
REQ-031 After reset, fetch branch at pc 0x0000_0010 -> prediction = 0, queue count 1; resolve res_taken = 1 -> mispredict = 1, counter[4] = 2'b10, mispredict_cnt = 1.
REQ-032 Three taken resolutions at pc 0x10 then a fourth fetch -> prediction = 1, counter[4] = 2'b11 and stays 2'b11 after a further taken resolution.
REQ-033 Four branch fetches without resolution, fifth branch fetch -> bp_stall = 1, prediction = 0; same cycle res_valid with correct outcome -> bp_stall = 0, push accepted, count stays 4.
REQ-034 Three entries queued, head mispredicts -> queue empty next cycle, concurrent branch fetch not pushed.
REQ-035 res_valid with empty queue -> res_err = 1 for exactly one cycle, all counters unchanged.
REQ-036 Assert rst_n low between clock edges with 2 entries queued -> queue empty and counters 2'b01 immediately, before next clk edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor slice.
// Opcode, default sizes, 2-bit counter encodings, queue entry.
package bp_pkg;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam int IDX_W_DEF   = 4;
  localparam int Q_DEPTH_DEF = 4;
  localparam int IDX_MAX     = 16;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // idx is sized for the widest supported table; unused upper bits are 0
  typedef struct packed {
    logic [IDX_MAX-1:0] idx;
    logic               pred;
  } bp_entry_t;

  function automatic logic [1:0] ctr_next(
    input logic [1:0] c,
    input logic       taken
  );
    logic [1:0] n;
    n = c;
    if (taken) begin
      if (c != ST) n = c + 2'd1;
    end else begin
      if (c != SNT) n = c - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_queue.sv
// In-flight prediction FIFO with pointer-compare full/empty.
// Ports: clk, rst_n, i_push/i_pop/i_clear, i_data, o_data, o_full, o_empty, o_count.
module bp_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = Q_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  bp_entry_t                i_data,
  output bp_entry_t                o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  bp_entry_t   r_mem [DEPTH];

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;
  assign o_data  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      // clear drops everything still queued, including the head being popped
      if (i_clear)     r_rd <= r_wr;
      else if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit predictor with in-flight queue and mispredict flush.
// Ports: fetch (if_*), prediction/bp_stall, resolve (res_*), mispredict, res_err, mispredict_cnt.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W   = IDX_W_DEF,
  parameter int Q_DEPTH = Q_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        prediction,
  output logic        bp_stall,
  input  logic        res_valid,
  input  logic        res_taken,
  output logic        mispredict,
  output logic        res_err,
  output logic [15:0] mispredict_cnt
);

  localparam int NE = 1 << IDX_W;
  localparam int QW = $clog2(Q_DEPTH);

  logic [1:0]       r_bht [NE];
  logic             r_err;
  logic [15:0]      r_mp_cnt;

  logic             w_branch;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_res;
  logic             w_mp;
  logic             w_stall;
  logic             w_pred;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [QW:0]      w_count;
  bp_entry_t        w_entry;
  bp_entry_t        w_head;
  logic             w_unused;

  assign w_branch   = if_valid && (if_inst[6:0] == OPCODE_BRANCH);
  assign w_idx      = if_pc[IDX_W+1:2];
  assign w_head_idx = w_head.idx[IDX_W-1:0];

  assign w_res   = res_valid && !w_empty;
  assign w_mp    = w_res && (res_taken != w_head.pred);
  // a same-cycle pop frees the slot the stalled fetch needs
  assign w_stall = w_branch && w_full && !w_res;
  assign w_pred  = w_branch && !w_stall && r_bht[w_idx][1];
  assign w_push  = w_branch && !w_stall && !w_mp;

  assign w_entry.idx  = IDX_MAX'(w_idx);
  assign w_entry.pred = w_pred;

  bp_queue #(
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_res),
    .i_clear (w_mp),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) r_bht[i] <= WNT;
    end else if (w_res) begin
      r_bht[w_head_idx] <= ctr_next(r_bht[w_head_idx], res_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err    <= 1'b0;
      r_mp_cnt <= '0;
    end else begin
      r_err <= res_valid && w_empty;
      if (w_mp && (r_mp_cnt != 16'hFFFF)) r_mp_cnt <= r_mp_cnt + 16'd1;
    end
  end

  assign prediction     = w_pred;
  assign bp_stall       = w_stall;
  assign mispredict     = w_mp;
  assign res_err        = r_err;
  assign mispredict_cnt = r_mp_cnt;

  assign w_unused = ^{if_pc[31:IDX_W+2], if_pc[1:0], if_inst[31:7],
                      w_head.idx[IDX_MAX-1:IDX_W], w_count};

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor.
// Reference model of BHT + queue; expected entries queued at fetch, checked at resolve.
module tb_branch_predictor;

  localparam int QD = 4;

  typedef struct {
    logic [3:0] idx;
    logic       pred;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        prediction;
  logic        bp_stall;
  logic        res_valid;
  logic        res_taken;
  logic        mispredict;
  logic        res_err;
  logic [15:0] mispredict_cnt;

  int n_chk;
  int n_fail;

  sb_t         sbq[$];
  logic [1:0]  m_bht [16];
  logic [15:0] m_cnt;
  logic        m_err;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .prediction     (prediction),
    .bp_stall       (bp_stall),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .mispredict     (mispredict),
    .res_err        (res_err),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  task automatic check_bht(input string tag);
    for (int i = 0; i < 16; i++) check(tag, dut.r_bht[i], m_bht[i]);
  endtask

  // one cycle: drive at negedge, check comb outputs, model at posedge
  task automatic cyc(input logic fv, input logic [31:0] pc,
                     input logic br, input logic rv, input logic rt);
    logic       fb, m_res, e_mp, e_stall, e_pred;
    logic [3:0] ix;
    sb_t        e;
    if_valid  = fv;
    if_pc     = pc;
    if_inst   = br ? 32'h0000_0063 : 32'h0000_0033;
    res_valid = rv;
    res_taken = rt;
    #1;
    fb      = fv && br;
    ix      = pc[5:2];
    m_res   = rv && (sbq.size() != 0);
    e_mp    = m_res && (rt != sbq[0].pred);
    e_stall = fb && (sbq.size() == QD) && !m_res;
    e_pred  = fb && !e_stall && m_bht[ix][1];
    check("prediction", prediction, e_pred);
    check("bp_stall", bp_stall, e_stall);
    check("mispredict", mispredict, e_mp);
    @(posedge clk);
    m_err = rv && (sbq.size() == 0);
    if (m_res) begin
      e = sbq.pop_front();
      if (rt) begin
        if (m_bht[e.idx] != 2'b11) m_bht[e.idx]++;
      end else begin
        if (m_bht[e.idx] != 2'b00) m_bht[e.idx]--;
      end
      if (e_mp) begin
        sbq.delete();
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
    end
    if (fb && !e_stall && !e_mp) begin
      e.idx  = ix;
      e.pred = e_pred;
      sbq.push_back(e);
    end
    @(negedge clk);
    check("res_err", res_err, m_err);
    check("mp_cnt", mispredict_cnt, m_cnt);
    check("count", dut.w_count, sbq.size());
  endtask

  function automatic logic head_pred();
    return sbq[0].pred;
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    if_valid  = 1'b0;
    if_pc     = '0;
    if_inst   = '0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_pred", prediction, 0);
    check("rst_stall", bp_stall, 0);
    check("rst_err", res_err, 0);
    check("rst_cnt", mispredict_cnt, 0);
    check("rst_count", dut.w_count, 0);
    check_bht("rst_bht");
    @(negedge clk);
    rst_n = 1'b1;

    // first fetch after reset, resolved taken
    cyc(1, 32'h10, 1, 0, 0);
    check("r31_count", dut.w_count, 1);
    cyc(0, 0, 0, 1, 1);
    check("r31_ctr", dut.r_bht[4], 2'b10);
    check("r31_cnt", mispredict_cnt, 1);

    // train to strongly taken and saturate
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h10, 1, 0, 0);
      cyc(0, 0, 0, 1, 1);
    end
    cyc(1, 32'h10, 1, 0, 0);
    check("r32_ctr", dut.r_bht[4], 2'b11);
    cyc(0, 0, 0, 1, 1);
    check("r32_sat", dut.r_bht[4], 2'b11);

    // fill queue, stalled fetch then same-cycle correct resolve
    for (int k = 0; k < 4; k++) cyc(1, 32'h20 + 4 * k, 1, 0, 0);
    cyc(1, 32'h40, 1, 0, 0);
    check("r33_stall_count", dut.w_count, 4);
    cyc(1, 32'h40, 1, 1, head_pred());
    check("r33_count", dut.w_count, 4);
    while (sbq.size() != 0) cyc(0, 0, 0, 1, head_pred());

    // head mispredicts with concurrent branch fetch
    for (int k = 0; k < 3; k++) cyc(1, 32'h50 + 4 * k, 1, 0, 0);
    cyc(1, 32'h60, 1, 1, !head_pred());
    check("r34_count", dut.w_count, 0);

    // resolve with empty queue
    cyc(0, 0, 0, 1, 1);
    check("r35_err", res_err, 1);
    cyc(0, 0, 0, 0, 0);
    check("r35_err_clr", res_err, 0);
    check_bht("r35_bht");

    // random traffic, including non-branch fetches against a full queue
    for (int k = 0; k < 400; k++) begin
      logic rv, rt;
      rv = ($urandom_range(0, 2) == 0);
      rt = (sbq.size() != 0 && $urandom_range(0, 3) != 0) ?
           head_pred() : 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 255),
          ($urandom_range(0, 3) != 0), rv, rt);
    end
    check_bht("rand_bht");

    // asynchronous reset with entries in flight
    while (sbq.size() != 0) cyc(0, 0, 0, 1, head_pred());
    cyc(1, 32'h10, 1, 0, 0);
    cyc(0, 0, 0, 1, !head_pred());
    cyc(1, 32'h14, 1, 0, 0);
    cyc(1, 32'h18, 1, 0, 0);
    check("r36_pre_count", dut.w_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("r36_count", dut.w_count, 0);
    check("r36_cnt", mispredict_cnt, 0);
    check("r36_err", res_err, 0);
    check_bht("r36_bht");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 32'h10, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
